// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operations, muldiv FSM states
// and small helpers used by exec_stage_fwd and muldiv_iter.
package exec_pkg;

   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,
      OP_SUB   = 5'd1,
      OP_AND   = 5'd2,
      OP_OR    = 5'd3,
      OP_XOR   = 5'd4,
      OP_NOR   = 5'd5,
      OP_SLT   = 5'd6,
      OP_SLTU  = 5'd7,
      OP_SLL   = 5'd8,
      OP_SRL   = 5'd9,
      OP_SRA   = 5'd10,
      OP_LUI   = 5'd11,
      OP_EQ    = 5'd12,
      OP_NE    = 5'd13,
      OP_MULT  = 5'd14,
      OP_MULTU = 5'd15,
      OP_DIV   = 5'd16,
      OP_DIVU  = 5'd17,
      OP_MFHI  = 5'd18,
      OP_MFLO  = 5'd19
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // SHAMT_W for a given datapath width
   function automatic int shamt_w(input int xlen);
      return $clog2(xlen);
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_mfhilo(input logic [4:0] op);
      return (op == OP_MFHI) || (op == OP_MFLO);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply (shift-add) / restoring divide with HI/LO.
// Present only when EXEC_MULDIV_EN is defined; otherwise busy/hi/lo are 0.
module muldiv_iter
   import exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            start,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);
`ifdef EXEC_MULDIV_EN
   localparam int CNT_W = $clog2(XLEN);

   md_state_e         state;
   logic [CNT_W-1:0]  cnt;
   logic              is_div, neg_q, neg_r, div0;
   logic [XLEN-1:0]   acc, sh, m;
   logic [XLEN-1:0]   acc_n, sh_n;
   logic [XLEN:0]     sum, trial;
   logic              sgn, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] prod, prod_fix;

   // Signed ops run on magnitudes; signs are re-applied at writeback.
   assign sgn   = (op == OP_MULT) || (op == OP_DIV);
   assign a_neg = sgn & a[XLEN-1];
   assign b_neg = sgn & b[XLEN-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   assign busy = (state == MD_BUSY) || ((state == MD_IDLE) && start && !RST);

   always_comb begin
      sum   = '0;
      trial = '0;
      acc_n = acc;
      sh_n  = sh;
      if (is_div) begin
         trial = {acc, sh[XLEN-1]} - {1'b0, m};
         if (trial[XLEN]) begin
            acc_n = {acc[XLEN-2:0], sh[XLEN-1]};
            sh_n  = {sh[XLEN-2:0], 1'b0};
         end else begin
            acc_n = trial[XLEN-1:0];
            sh_n  = {sh[XLEN-2:0], 1'b1};
         end
      end else begin
         sum   = {1'b0, acc} + (sh[0] ? {1'b0, m} : '0);
         acc_n = sum[XLEN:1];
         sh_n  = {sum[0], sh[XLEN-1:1]};
      end
   end

   assign prod     = {acc_n, sh_n};
   assign prod_fix = neg_q ? -prod : prod;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= MD_IDLE;
         cnt    <= '0;
         acc    <= '0;
         sh     <= '0;
         m      <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            MD_IDLE: if (start) begin
               state  <= MD_BUSY;
               cnt    <= CNT_W'(XLEN-1);
               is_div <= (op == OP_DIV) || (op == OP_DIVU);
               neg_q  <= a_neg ^ b_neg;
               neg_r  <= a_neg;
               div0   <= (b == '0);
               acc    <= '0;
               sh     <= a_mag;
               m      <= b_mag;
            end
            MD_BUSY: begin
               acc <= acc_n;
               sh  <= sh_n;
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state <= MD_DONE;
                  if (is_div) begin
                     lo <= div0 ? '1 : (neg_q ? -sh_n : sh_n);
                     hi <= neg_r ? -acc_n : acc_n;
                  end else begin
                     {hi, lo} <= prod_fix;
                  end
               end
            end
            default: state <= MD_IDLE;
         endcase
      end
   end
`else
   logic unused_md;
   assign unused_md = ^{CLK, RST, start, op, a, b};
   assign busy = 1'b0;
   assign hi   = '0;
   assign lo   = '0;
`endif
endmodule

// File: rtl/exec_stage_fwd.sv
// Execute stage: MEM/WB operand forwarding, ALU and the EX/MEM register.
// Optional iterative mul/div with HI/LO is enabled by EXEC_MULDIV_EN.
module exec_stage_fwd
   import exec_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   input  logic [4:0]      alu_op,
   input  logic            alu_src,
   input  logic            reg_dst,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            mem_to_reg,
   input  logic            reg_write,
   input  logic [REGW-1:0] rs_addr,
   input  logic [REGW-1:0] rt_addr,
   input  logic [REGW-1:0] rd_addr,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] rt_data,
   input  logic [XLEN-1:0] imm,
   input  logic            mem_fwd_we,
   input  logic            wb_fwd_we,
   input  logic [REGW-1:0] mem_fwd_rd,
   input  logic [REGW-1:0] wb_fwd_rd,
   input  logic [XLEN-1:0] mem_fwd_data,
   input  logic [XLEN-1:0] wb_fwd_data,
   output logic            stall,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_alu_out,
   output logic            ex_zero,
   output logic [XLEN-1:0] ex_store_data,
   output logic [REGW-1:0] ex_dest,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_mem_to_reg,
   output logic            ex_reg_write
);
   localparam int SHAMT_W = shamt_w(XLEN);

   alu_op_e            op;
   logic [XLEN-1:0]    op_a, rt_fwd, op_b, alu_res, md_hi, md_lo;
   logic [SHAMT_W-1:0] shamt;
   logic               md_busy, kill_wr, issue;

   assign op    = alu_op_e'(alu_op);
   assign shamt = imm[SHAMT_W+5:6];

   always_comb begin
      op_a = rs_data;
      if (mem_fwd_we && mem_fwd_rd != '0 && mem_fwd_rd == rs_addr)
         op_a = mem_fwd_data;
      else if (wb_fwd_we && wb_fwd_rd != '0 && wb_fwd_rd == rs_addr)
         op_a = wb_fwd_data;
      rt_fwd = rt_data;
      if (mem_fwd_we && mem_fwd_rd != '0 && mem_fwd_rd == rt_addr)
         rt_fwd = mem_fwd_data;
      else if (wb_fwd_we && wb_fwd_rd != '0 && wb_fwd_rd == rt_addr)
         rt_fwd = wb_fwd_data;
   end

   assign op_b = alu_src ? imm : rt_fwd;

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_NOR:  alu_res = ~(op_a | op_b);
         OP_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
         OP_SLTU: alu_res = XLEN'(op_a < op_b);
         OP_SLL:  alu_res = rt_fwd << shamt;
         OP_SRL:  alu_res = rt_fwd >> shamt;
         OP_SRA:  alu_res = $signed(rt_fwd) >>> shamt;
         OP_LUI:  alu_res = imm << (XLEN/2);
         OP_EQ:   alu_res = XLEN'(op_a == op_b);
         OP_NE:   alu_res = XLEN'(op_a != op_b);
         OP_MFHI: alu_res = md_hi;
         OP_MFLO: alu_res = md_lo;
         default: alu_res = '0;
      endcase
   end

   // Without the unit, HI/LO moves must not write back their dummy zero.
`ifdef EXEC_MULDIV_EN
   assign kill_wr = is_muldiv(alu_op);
`else
   assign kill_wr = is_muldiv(alu_op) | is_mfhilo(alu_op);
`endif

   muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .CLK   (CLK),
      .RST   (RST),
      .start (in_valid & is_muldiv(alu_op)),
      .op    (alu_op),
      .a     (op_a),
      .b     (rt_fwd),
      .busy  (md_busy),
      .hi    (md_hi),
      .lo    (md_lo)
   );

   assign stall = md_busy;
   assign issue = in_valid & ~stall;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_valid      <= 1'b0;
         ex_alu_out    <= '0;
         ex_zero       <= 1'b0;
         ex_store_data <= '0;
         ex_dest       <= '0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_reg_write  <= 1'b0;
      end else begin
         ex_valid      <= issue;
         ex_alu_out    <= alu_res;
         ex_zero       <= (alu_res == '0);
         ex_store_data <= rt_fwd;
         ex_dest       <= reg_dst ? rd_addr : rt_addr;
         ex_mem_read   <= issue & mem_read;
         ex_mem_write  <= issue & mem_write;
         ex_mem_to_reg <= issue & mem_to_reg;
         ex_reg_write  <= issue & reg_write & ~kill_wr;
      end
   end
endmodule

// File: tb/tb_exec_stage_fwd.sv
// Randomized and directed bench for exec_stage_fwd against a behavioural model.
module tb_exec_stage_fwd;
   import exec_pkg::*;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   logic            CLK = 1'b0;
   logic            RST;
   logic            in_valid, alu_src, reg_dst;
   logic [4:0]      alu_op;
   logic            mem_read, mem_write, mem_to_reg, reg_write;
   logic [REGW-1:0] rs_addr, rt_addr, rd_addr;
   logic [XLEN-1:0] rs_data, rt_data, imm;
   logic            mem_fwd_we, wb_fwd_we;
   logic [REGW-1:0] mem_fwd_rd, wb_fwd_rd;
   logic [XLEN-1:0] mem_fwd_data, wb_fwd_data;
   logic            stall, ex_valid, ex_zero;
   logic [XLEN-1:0] ex_alu_out, ex_store_data;
   logic [REGW-1:0] ex_dest;
   logic            ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;

   int n_tests = 0;
   int n_fail  = 0;

   exec_stage_fwd #(.XLEN(XLEN), .REGW(REGW)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .alu_op(alu_op), .alu_src(alu_src),
      .reg_dst(reg_dst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rs_addr(rs_addr),
      .rt_addr(rt_addr), .rd_addr(rd_addr), .rs_data(rs_data), .rt_data(rt_data),
      .imm(imm), .mem_fwd_we(mem_fwd_we), .wb_fwd_we(wb_fwd_we),
      .mem_fwd_rd(mem_fwd_rd), .wb_fwd_rd(wb_fwd_rd), .mem_fwd_data(mem_fwd_data),
      .wb_fwd_data(wb_fwd_data), .stall(stall), .ex_valid(ex_valid),
      .ex_alu_out(ex_alu_out), .ex_zero(ex_zero), .ex_store_data(ex_store_data),
      .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_instr(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic src);
      in_valid = 1'b1; alu_op = op; alu_src = src; reg_dst = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b1;
      rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd3;
      rs_data = a; rt_data = b; imm = im;
      mem_fwd_we = 1'b0; wb_fwd_we = 1'b0; mem_fwd_rd = '0; wb_fwd_rd = '0;
      mem_fwd_data = '0; wb_fwd_data = '0;
   endtask

   // A source resolves to the youngest writer of that register; r0 is never forwarded.
   function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] rf);
      logic [31:0] v;
      v = rf;
      if (addr != 0 && wb_fwd_we && wb_fwd_rd == addr)   v = wb_fwd_data;
      if (addr != 0 && mem_fwd_we && mem_fwd_rd == addr) v = mem_fwd_data;
      return v;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] rt,
                                           input logic [31:0] im);
      longint sa, sb, srt, p;
      logic [63:0] w;
      int sh;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      srt = longint'($signed(rt));
      sh  = int'(im[10:6]);
      p   = longint'(1) << sh;
      case (alu_op_e'(op))
         OP_ADD:  w = 64'(a) + 64'(b);
         OP_SUB:  w = 64'(a) - 64'(b);
         OP_AND:  w = 64'(a & b);
         OP_OR:   w = 64'(a | b);
         OP_XOR:  w = 64'(a ^ b);
         OP_NOR:  w = 64'(~(a | b));
         OP_SLT:  w = (sa < sb) ? 64'd1 : 64'd0;
         OP_SLTU: w = (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
         OP_SLL:  w = 64'(rt) * 64'(p);
         OP_SRL:  w = 64'(rt) / 64'(p);
         OP_SRA:  w = (srt >= 0) ? 64'(srt / p) : 64'(-((-srt + p - 1) / p));
         OP_LUI:  w = 64'(im) * 64'd65536;
         OP_EQ:   w = (a == b) ? 64'd1 : 64'd0;
         OP_NE:   w = (a != b) ? 64'd1 : 64'd0;
         default: w = 64'd0;
      endcase
      return w[31:0];
   endfunction

`ifdef EXEC_MULDIV_EN
   function automatic logic [63:0] ref_md(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] w;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      w  = 64'd0;
      case (alu_op_e'(op))
         OP_MULT:  w = 64'(sa * sb);
         OP_MULTU: w = 64'(a) * 64'(b);
         OP_DIV:   if (b == 0) w = {a, 32'hFFFF_FFFF};
                   else begin q = sa / sb; r = sa % sb; w = {r[31:0], q[31:0]}; end
         OP_DIVU:  if (b == 0) w = {a, 32'hFFFF_FFFF};
                   else w = {a % b, a / b};
         default:  w = 64'd0;
      endcase
      return w;
   endfunction

   // Issue a muldiv, hold it while stalled, retire it; return stall length.
   task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
      set_instr(op, a, b, 32'd0, 1'b0);
      n = 0;
      #2;
      while (stall && n < 200) begin
         n++;
         @(posedge CLK);
         #3;
      end
      tick();
      check("md_retire_valid", 64'(ex_valid), 64'd1);
      check("md_retire_regwr", 64'(ex_reg_write), 64'd0);
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      set_instr(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0);
      tick();
      check({tag, "_lo"}, 64'(ex_alu_out), 64'(exp_lo));
      set_instr(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0);
      tick();
      check({tag, "_hi"}, 64'(ex_alu_out), 64'(exp_hi));
      check({tag, "_mf_regwr"}, 64'(ex_reg_write), 64'd1);
   endtask
`endif

   initial begin
      RST = 1'b1;
      set_instr(OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      in_valid = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_valid", 64'(ex_valid), 64'd0);
      check("rst_alu", 64'(ex_alu_out), 64'd0);
      check("rst_zero", 64'(ex_zero), 64'd0);
      check("rst_store", 64'(ex_store_data), 64'd0);
      check("rst_dest", 64'(ex_dest), 64'd0);
      check("rst_regwr", 64'(ex_reg_write), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      RST = 1'b0;

      set_instr(OP_ADD, 32'd5, 32'hFFFF_FFFE, 32'd0, 1'b0);
      #2 check("add_stall", 64'(stall), 64'd0);
      tick();
      check("add_res", 64'(ex_alu_out), 64'd3);
      check("add_zero", 64'(ex_zero), 64'd0);
      check("add_valid", 64'(ex_valid), 64'd1);
      check("add_dest", 64'(ex_dest), 64'd3);

      set_instr(OP_ADD, 32'd100, 32'd0, 32'd0, 1'b0);
      rs_addr = 5'd4; rt_addr = 5'd0;
      mem_fwd_we = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'd7;
      wb_fwd_we = 1'b1;  wb_fwd_rd = 5'd4;  wb_fwd_data = 32'd9;
      tick();
      check("fwd_mem_wins", 64'(ex_alu_out), 64'd7);
      mem_fwd_we = 1'b0;
      tick();
      check("fwd_wb", 64'(ex_alu_out), 64'd9);
      mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
      rs_addr = 5'd0; rs_data = 32'd100;
      tick();
      check("fwd_r0_rf", 64'(ex_alu_out), 64'd100);

      set_instr(OP_OR, 32'd0, 32'd55, 32'd1, 1'b1);
      rs_addr = 5'd0;
      tick();
      check("ori", 64'(ex_alu_out), 64'd1);
      set_instr(OP_EQ, 32'd1, 32'd0, 32'd0, 1'b0);
      tick();
      check("eq_res", 64'(ex_alu_out), 64'd0);
      check("eq_zero", 64'(ex_zero), 64'd1);
      set_instr(OP_NE, 32'd1, 32'd0, 32'd0, 1'b0);
      tick();
      check("ne_res", 64'(ex_alu_out), 64'd1);
      check("ne_zero", 64'(ex_zero), 64'd0);

      set_instr(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0);
      mem_read = 1'b1; in_valid = 1'b0;
      tick();
      check("bubble_valid", 64'(ex_valid), 64'd0);
      check("bubble_regwr", 64'(ex_reg_write), 64'd0);
      check("bubble_mread", 64'(ex_mem_read), 64'd0);

      for (int i = 0; i < 200; i++) begin
         logic [31:0] a, rtv, b, r;
         logic        v, rw, mr, mw, m2r;
         logic [4:0]  dst;
         set_instr(5'($urandom_range(0, 13)), $urandom, $urandom, $urandom, 1'($urandom));
         in_valid = ($urandom_range(0, 7) != 0);
         reg_dst = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
         mem_to_reg = 1'($urandom); reg_write = 1'($urandom);
         rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3));
         rd_addr = 5'($urandom);
         if ($urandom_range(0, 3) == 0) rt_data = rs_data;
         if ($urandom_range(0, 3) == 0) rs_data = 32'd0;
         mem_fwd_we = 1'($urandom); mem_fwd_rd = 5'($urandom_range(0, 3)); mem_fwd_data = $urandom;
         wb_fwd_we = 1'($urandom);  wb_fwd_rd = 5'($urandom_range(0, 3));  wb_fwd_data = $urandom;
         a   = ref_fwd(rs_addr, rs_data);
         rtv = ref_fwd(rt_addr, rt_data);
         b   = alu_src ? imm : rtv;
         r   = ref_alu(alu_op, a, b, rtv, imm);
         v = in_valid; rw = in_valid & reg_write; mr = in_valid & mem_read;
         mw = in_valid & mem_write; m2r = in_valid & mem_to_reg;
         dst = reg_dst ? rd_addr : rt_addr;
         #2 check("rnd_stall", 64'(stall), 64'd0);
         tick();
         check("rnd_valid", 64'(ex_valid), 64'(v));
         check("rnd_regwr", 64'(ex_reg_write), 64'(rw));
         check("rnd_mctl", 64'({ex_mem_read, ex_mem_write, ex_mem_to_reg}), 64'({mr, mw, m2r}));
         if (v) begin
            check("rnd_alu", 64'(ex_alu_out), 64'(r));
            check("rnd_zero", 64'(ex_zero), 64'(r == 0));
            check("rnd_store", 64'(ex_store_data), 64'(rtv));
            check("rnd_dest", 64'(ex_dest), 64'(dst));
         end
      end

`ifdef EXEC_MULDIV_EN
      begin
         int n;
         logic [63:0] e;
         run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
         check("div_stall_cycles", 64'(n), 64'd33);
         read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
         run_md(OP_DIVU, 32'd5, 32'd0, n);
         read_hilo("divu0", 32'd5, 32'hFFFF_FFFF);
         run_md(OP_MULTU, 32'hFFFF_FFFF, 32'd2, n);
         read_hilo("multu", 32'd1, 32'hFFFF_FFFE);
         for (int k = 0; k < 6; k++) begin
            logic [4:0]  o;
            logic [31:0] x, y;
            o = 5'($urandom_range(14, 17));
            x = $urandom;
            y = (k == 5) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            e = ref_md(o, x, y);
            run_md(o, x, y, n);
            check("rnd_md_stall", 64'(n), 64'd33);
            read_hilo("rnd_md", e[63:32], e[31:0]);
         end
         // Abort a multiply mid-flight; HI/LO must come back cleared.
         set_instr(OP_MULT, 32'd1234, 32'd77, 32'd0, 1'b0);
         #2 check("mult_stall_issue", 64'(stall), 64'd1);
         repeat (10) @(posedge CLK);
         #1 RST = 1'b1;
         #1;
         check("abort_stall", 64'(stall), 64'd0);
         check("abort_valid", 64'(ex_valid), 64'd0);
         check("abort_store", 64'(ex_store_data), 64'd0);
         check("abort_dest", 64'(ex_dest), 64'd0);
         @(posedge CLK);
         #1 RST = 1'b0;
         set_instr(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0);
         tick();
         check("abort_hi", 64'(ex_alu_out), 64'd0);
         set_instr(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0);
         tick();
         check("abort_lo", 64'(ex_alu_out), 64'd0);
      end
`else
      set_instr(OP_MULT, 32'd3, 32'd4, 32'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #2 check("mult_nostall", 64'(stall), 64'd0);
         tick();
         check("mult_valid", 64'(ex_valid), 64'd1);
         check("mult_res", 64'(ex_alu_out), 64'd0);
         check("mult_regwr", 64'(ex_reg_write), 64'd0);
      end
      set_instr(OP_DIVU, 32'd9, 32'd3, 32'd0, 1'b0);
      tick();
      check("divu_res", 64'(ex_alu_out), 64'd0);
      set_instr(OP_MFHI, 32'd5, 32'd6, 32'd0, 1'b0);
      tick();
      check("mfhi_res", 64'(ex_alu_out), 64'd0);
      check("mfhi_regwr", 64'(ex_reg_write), 64'd0);
      check("mfhi_valid", 64'(ex_valid), 64'd1);
      set_instr(OP_MULT, 32'd3, 32'd4, 32'd0, 1'b0);
      #1 RST = 1'b1;
      #1;
      check("rst_mid_stall", 64'(stall), 64'd0);
      check("rst_mid_valid", 64'(ex_valid), 64'd0);
      check("rst_mid_store", 64'(ex_store_data), 64'd0);
      @(posedge CLK);
      #1 RST = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
